// File: rtl/l2_flush_walker.sv
// l2_flush_walker: walks every L2 set/way during a flush and issues one eviction per eligible line.
// Optional L2_FLUSH_PERF_CNT_EN adds flush_evict_cnt, the number of evict handshakes in the current flush.
module l2_flush_walker #(
  parameter int unsigned L2_SETS = 256,
  parameter int unsigned L2_WAYS = 8,
  parameter int unsigned N_REQS  = 4,
  localparam int unsigned L2_SET_BITS  = $clog2(L2_SETS),
  localparam int unsigned L2_WAY_BITS  = $clog2(L2_WAYS),
  localparam int unsigned REQS_BITS_P1 = $clog2(N_REQS) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_valid,
  input  logic                    flush_dcache_only,
  output logic                    flush_ready,
  input  logic [L2_SET_BITS:0]    flush_set,
  input  logic [L2_WAY_BITS:0]    flush_way,
  input  logic [REQS_BITS_P1-1:0] reqs_cnt,
  output logic                    set_ongoing_flush,
  output logic                    clr_ongoing_flush,
  output logic                    clr_flush_set,
  output logic                    incr_flush_set,
  output logic                    clr_flush_way,
  output logic                    incr_flush_way,
  output logic                    fill_reqs_flush,
  output logic                    rd_en,
  input  logic [1:0]              rd_state,
  input  logic                    rd_hprot,
  output logic                    evict_valid,
  input  logic                    evict_ready,
  output logic [L2_SET_BITS-1:0]  evict_set,
  output logic [L2_WAY_BITS-1:0]  evict_way,
  output logic                    evict_dirty,
  output logic                    flush_done
`ifdef L2_FLUSH_PERF_CNT_EN
  ,
  output logic [15:0]             flush_evict_cnt
`endif
);

  localparam int unsigned SET_W = L2_SET_BITS + 1;
  localparam int unsigned WAY_W = L2_WAY_BITS + 1;
  localparam logic [1:0] ST_INVALID  = 2'd0;
  localparam logic [1:0] ST_MODIFIED = 2'd3;
  localparam logic [SET_W-1:0]        LAST_SET = SET_W'(L2_SETS - 1);
  localparam logic [WAY_W-1:0]        LAST_WAY = WAY_W'(L2_WAYS - 1);
  localparam logic [REQS_BITS_P1-1:0] ALL_FREE = REQS_BITS_P1'(N_REQS);

  typedef enum logic [2:0] {IDLE, READ, CHECK, DRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   pend_q, pend_d;
  logic                   dcache_only_q, dcache_only_d;
  logic                   evict_valid_q, evict_valid_d;
  logic [L2_SET_BITS-1:0] evict_set_q, evict_set_d;
  logic [L2_WAY_BITS-1:0] evict_way_q, evict_way_d;
  logic                   evict_dirty_q, evict_dirty_d;
  logic                   flush_ready_q, flush_ready_d;
  logic                   rd_en_q, rd_en_d;
  logic                   flush_done_q, flush_done_d;
  logic                   clr_ongoing_q, clr_ongoing_d;
  logic                   eligible, advance;
`ifdef L2_FLUSH_PERF_CNT_EN
  logic [15:0]            evict_cnt_q, evict_cnt_d;
`endif

  // Counter strobes and credit consumption are same-cycle so l2_regs reflects them before the next read.
  always_comb begin
    state_d           = state_q;
    pend_d            = pend_q;
    dcache_only_d     = dcache_only_q;
    evict_valid_d     = evict_valid_q;
    evict_set_d       = evict_set_q;
    evict_way_d       = evict_way_q;
    evict_dirty_d     = evict_dirty_q;
    set_ongoing_flush = 1'b0;
    clr_flush_set     = 1'b0;
    incr_flush_set    = 1'b0;
    clr_flush_way     = 1'b0;
    incr_flush_way    = 1'b0;
    fill_reqs_flush   = 1'b0;
    advance           = 1'b0;
    eligible          = (rd_state != ST_INVALID) && !(dcache_only_q && !rd_hprot);

    case (state_q)
      IDLE: begin
        if (flush_valid) begin
          set_ongoing_flush = 1'b1;
          clr_flush_set     = 1'b1;
          clr_flush_way     = 1'b1;
          dcache_only_d     = flush_dcache_only;
          state_d           = READ;
        end
      end
      READ: state_d = CHECK;
      CHECK: begin
        if (evict_valid_q) begin
          if (evict_ready) begin
            fill_reqs_flush = 1'b1;
            evict_valid_d   = 1'b0;
            pend_d          = 1'b0;
            advance         = 1'b1;
          end
        end else if (pend_q || eligible) begin
          // Payload is captured on the read-data cycle so a credit stall cannot corrupt it.
          if (!pend_q) begin
            evict_set_d   = flush_set[L2_SET_BITS-1:0];
            evict_way_d   = flush_way[L2_WAY_BITS-1:0];
            evict_dirty_d = (rd_state == ST_MODIFIED);
          end
          pend_d = 1'b1;
          if (reqs_cnt != '0) evict_valid_d = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      DRAIN: if (reqs_cnt == ALL_FREE) state_d = DONE;
      DONE: begin
        clr_flush_set = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (flush_way < LAST_WAY) begin
        incr_flush_way = 1'b1;
      end else begin
        clr_flush_way  = 1'b1;
        incr_flush_set = 1'b1;
      end
      state_d = ((flush_set == LAST_SET) && (flush_way == LAST_WAY)) ? DRAIN : READ;
    end

    flush_ready_d = (state_d == IDLE);
    rd_en_d       = (state_d == READ);
    flush_done_d  = (state_d == DONE);
    clr_ongoing_d = (state_d == DONE);

`ifdef L2_FLUSH_PERF_CNT_EN
    evict_cnt_d = evict_cnt_q;
    if ((state_q == IDLE) && flush_valid) evict_cnt_d = '0;
    else if (fill_reqs_flush && (evict_cnt_q != 16'hFFFF)) evict_cnt_d = evict_cnt_q + 16'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pend_q        <= 1'b0;
      dcache_only_q <= 1'b0;
      evict_valid_q <= 1'b0;
      evict_set_q   <= '0;
      evict_way_q   <= '0;
      evict_dirty_q <= 1'b0;
      flush_ready_q <= 1'b1;
      rd_en_q       <= 1'b0;
      flush_done_q  <= 1'b0;
      clr_ongoing_q <= 1'b0;
`ifdef L2_FLUSH_PERF_CNT_EN
      evict_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      dcache_only_q <= dcache_only_d;
      evict_valid_q <= evict_valid_d;
      evict_set_q   <= evict_set_d;
      evict_way_q   <= evict_way_d;
      evict_dirty_q <= evict_dirty_d;
      flush_ready_q <= flush_ready_d;
      rd_en_q       <= rd_en_d;
      flush_done_q  <= flush_done_d;
      clr_ongoing_q <= clr_ongoing_d;
`ifdef L2_FLUSH_PERF_CNT_EN
      evict_cnt_q   <= evict_cnt_d;
`endif
    end
  end

  assign flush_ready       = flush_ready_q;
  assign rd_en             = rd_en_q;
  assign evict_valid       = evict_valid_q;
  assign evict_set         = evict_set_q;
  assign evict_way         = evict_way_q;
  assign evict_dirty       = evict_dirty_q;
  assign flush_done        = flush_done_q;
  assign clr_ongoing_flush = clr_ongoing_q;
`ifdef L2_FLUSH_PERF_CNT_EN
  assign flush_evict_cnt   = evict_cnt_q;
`endif

endmodule

// File: tb/tb_l2_flush_walker.sv
// tb_l2_flush_walker: scoreboard bench for l2_flush_walker on a 4-set x 2-way cache,
// with a behavioural l2_regs / tag-state model around the walker.
module tb_l2_flush_walker;

  localparam int unsigned SETS = 4;
  localparam int unsigned WAYS = 2;
  localparam int unsigned NREQ = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush_valid = 1'b0;
  logic       flush_dcache_only = 1'b0;
  logic       flush_ready;
  logic [2:0] fs = 3'd0;
  logic [1:0] fw = 2'd0;
  logic [2:0] reqs_cnt;
  logic [2:0] reqs_auto = 3'd4;
  logic       man_en = 1'b0;
  logic [2:0] man_val = 3'd0;
  logic       ongoing = 1'b0;
  logic       set_ongoing_flush, clr_ongoing_flush, clr_flush_set, incr_flush_set;
  logic       clr_flush_way, incr_flush_way, fill_reqs_flush, rd_en;
  logic [1:0] rd_state = 2'd0;
  logic       rd_hprot = 1'b0;
  logic       evict_valid;
  logic       evict_ready = 1'b0;
  logic [1:0] evict_set;
  logic       evict_way;
  logic       evict_dirty;
  logic       flush_done;
`ifdef L2_FLUSH_PERF_CNT_EN
  logic [15:0] flush_evict_cnt;
`endif

  logic [1:0] mem_state [SETS][WAYS];
  logic       mem_hprot [SETS][WAYS];

  typedef struct {int s; int w; int d;} ev_t;
  ev_t exp_q[$];

  int tests = 0, fails = 0;
  int hs_cnt = 0, fill_cnt = 0, done_cnt = 0;
  int lat, hs0, done0;

  assign reqs_cnt = man_en ? man_val : reqs_auto;

  l2_flush_walker #(.L2_SETS(SETS), .L2_WAYS(WAYS), .N_REQS(NREQ)) dut (
    .clk(clk), .rst(rst),
    .flush_valid(flush_valid), .flush_dcache_only(flush_dcache_only), .flush_ready(flush_ready),
    .flush_set(fs), .flush_way(fw), .reqs_cnt(reqs_cnt),
    .set_ongoing_flush(set_ongoing_flush), .clr_ongoing_flush(clr_ongoing_flush),
    .clr_flush_set(clr_flush_set), .incr_flush_set(incr_flush_set),
    .clr_flush_way(clr_flush_way), .incr_flush_way(incr_flush_way),
    .fill_reqs_flush(fill_reqs_flush), .rd_en(rd_en),
    .rd_state(rd_state), .rd_hprot(rd_hprot),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_set(evict_set), .evict_way(evict_way), .evict_dirty(evict_dirty),
    .flush_done(flush_done)
`ifdef L2_FLUSH_PERF_CNT_EN
    , .flush_evict_cnt(flush_evict_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // l2_regs counters, request credits (retire one per idle cycle) and the tag/state array.
  always @(posedge clk) begin
    if (clr_flush_set) fs <= 3'd0;
    else if (incr_flush_set) fs <= fs + 3'd1;
    if (clr_flush_way) fw <= 2'd0;
    else if (incr_flush_way) fw <= fw + 2'd1;
    if (set_ongoing_flush) ongoing <= 1'b1;
    else if (clr_ongoing_flush) ongoing <= 1'b0;
    if (fill_reqs_flush) reqs_auto <= reqs_auto - 3'd1;
    else if (reqs_auto < 3'(NREQ)) reqs_auto <= reqs_auto + 3'd1;
    if (rd_en) begin
      rd_state <= mem_state[int'(fs[1:0])][int'(fw[0])];
      rd_hprot <= mem_hprot[int'(fs[1:0])][int'(fw[0])];
    end
  end

  // Monitor: pops the scoreboard on every eviction handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (evict_valid && evict_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL evict_unexpected: got set=%0d way=%0d, expected no eviction", evict_set, evict_way);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("evict_set", int'(evict_set), e.s);
          check("evict_way", int'(evict_way), e.w);
          check("evict_dirty", int'(evict_dirty), e.d);
        end
      end
      if (fill_reqs_flush) fill_cnt++;
      if (flush_done) done_cnt++;
      if (incr_flush_set || clr_flush_set || incr_flush_way || clr_flush_way)
        check("strobe_conflict", int'((incr_flush_set && clr_flush_set) || (incr_flush_way && clr_flush_way)), 0);
    end
  end

  task automatic clear_mem();
    for (int s = 0; s < int'(SETS); s++)
      for (int w = 0; w < int'(WAYS); w++) begin
        mem_state[s][w] = 2'd0;
        mem_hprot[s][w] = 1'b1;
      end
  endtask

  task automatic start_flush(input logic dco);
    @(negedge clk);
    check("flush_ready_idle", int'(flush_ready), 1);
    flush_valid = 1'b1;
    flush_dcache_only = dco;
    @(posedge clk);
    @(negedge clk);
    flush_valid = 1'b0;
    flush_dcache_only = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      #1;
      if (flush_done) break;
    end
    check(nm, int'(flush_done), 1);
  endtask

  initial begin
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_flush_ready", int'(flush_ready), 1);
    check("rst_evict_valid", int'(evict_valid), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_flush_done", int'(flush_done), 0);
    check("rst_clr_ongoing", int'(clr_ongoing_flush), 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: all lines invalid
    hs0 = hs_cnt;
    evict_ready = 1'b1;
    start_flush(1'b0);
    wait_done("t1_done", lat);
    check("t1_latency", lat, 17);
    check("t1_evicts", hs_cnt - hs0, 0);
    @(posedge clk); #1;
    check("t1_flush_set_clr", int'(fs), 0);
    check("t1_flush_way_clr", int'(fw), 0);
    check("t1_ongoing_clr", int'(ongoing), 0);
    check("t1_ready_again", int'(flush_ready), 1);

    // 2: one modified line, sink always ready
    clear_mem();
    mem_state[1][1] = 2'd3;
    exp_q.push_back('{1, 1, 1});
    hs0 = hs_cnt;
    fill_cnt = 0;
    start_flush(1'b0);
    wait_done("t2_done", lat);
    check("t2_evicts", hs_cnt - hs0, 1);
    check("t2_fills", fill_cnt, 1);
    check("t2_queue_empty", exp_q.size(), 0);
`ifdef L2_FLUSH_PERF_CNT_EN
    check("t2_perf_cnt", int'(flush_evict_cnt), 1);
`endif
    @(negedge clk);

    // 3: eligible line starved of request credits
    clear_mem();
    mem_state[0][0] = 2'd2;
    exp_q.push_back('{0, 0, 0});
    man_en = 1'b1;
    man_val = 3'd0;
    start_flush(1'b0);
    for (int i = 0; i < 12; i++) begin
      check("t3_no_valid_without_credit", int'(evict_valid), 0);
      @(negedge clk);
    end
    man_val = 3'd1;
    check("t3_valid_before_credit_edge", int'(evict_valid), 0);
    @(posedge clk); #1;
    check("t3_valid_after_credit", int'(evict_valid), 1);
    @(negedge clk);
    man_en = 1'b0;
    wait_done("t3_done", lat);
    check("t3_queue_empty", exp_q.size(), 0);
    @(negedge clk);

    // 4: backpressure holds valid and payload
    clear_mem();
    mem_state[2][0] = 2'd3;
    mem_hprot[2][0] = 1'b0;
    exp_q.push_back('{2, 0, 1});
    evict_ready = 1'b0;
    start_flush(1'b0);
    lat = 0;
    while (lat < 50 && !evict_valid) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t4_valid_seen", int'(evict_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", int'(evict_valid), 1);
      check("t4_hold_set", int'(evict_set), 2);
      check("t4_hold_way", int'(evict_way), 0);
      check("t4_hold_dirty", int'(evict_dirty), 1);
      check("t4_walk_stalled", int'(fs), 2);
      check("t4_ongoing", int'(ongoing), 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    evict_ready = 1'b1;
    wait_done("t4_done", lat);
    check("t4_queue_empty", exp_q.size(), 0);
    @(negedge clk);

    // 5: dcache-only skips instruction lines
    clear_mem();
    mem_state[0][1] = 2'd1;
    mem_hprot[0][1] = 1'b0;
    mem_state[3][0] = 2'd1;
    mem_hprot[3][0] = 1'b1;
    exp_q.push_back('{3, 0, 0});
    hs0 = hs_cnt;
    start_flush(1'b1);
    wait_done("t5_done", lat);
    check("t5_evicts", hs_cnt - hs0, 1);
    check("t5_queue_empty", exp_q.size(), 0);
`ifdef L2_FLUSH_PERF_CNT_EN
    check("t5_perf_cnt", int'(flush_evict_cnt), 1);
`endif
    @(negedge clk);

    // 6: asynchronous reset while an eviction is pending
    clear_mem();
    mem_state[1][0] = 2'd3;
    exp_q.push_back('{1, 0, 1});
    evict_ready = 1'b0;
    start_flush(1'b0);
    lat = 0;
    while (lat < 50 && !evict_valid) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t6_valid_seen", int'(evict_valid), 1);
    done0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    check("t6_rst_evict_valid", int'(evict_valid), 0);
    check("t6_rst_flush_ready", int'(flush_ready), 1);
    check("t6_rst_rd_en", int'(rd_en), 0);
    check("t6_rst_fill", int'(fill_reqs_flush), 0);
    check("t6_rst_flush_done", int'(flush_done), 0);
    check("t6_rst_evict_dirty", int'(evict_dirty), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    evict_ready = 1'b1;
    clear_mem();
    check("t6_no_done_pulse", done_cnt - done0, 0);
    start_flush(1'b0);
    check("t6_restart_rd_en", int'(rd_en), 1);
    check("t6_restart_set", int'(fs), 0);
    check("t6_restart_way", int'(fw), 0);
    wait_done("t6_done", lat);
    check("t6_latency", lat, 17);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected $finish before 200000");
    $fatal(1);
  end

endmodule
